// File: rtl/usb_sie_pkt_buffer.sv
// Receive packet buffer: bytes are stored speculatively and exposed to the reader only once committed.
// Optional macro USB_SIE_PKT_LEN_EN adds a per-packet length FIFO and the rdPktLen_o port.
module usb_sie_pkt_buffer #(
  parameter int DEPTH    = 64,
  parameter int MAX_PKTS = 8
) (
  input  logic                   clk12_i,
  input  logic                   rst_i,
  input  logic                   wrDataValid_i,
  input  logic [7:0]             wrData_i,
  input  logic                   wrIsLastByte_i,
  input  logic                   wrKeepPacket_i,
  input  logic                   rdAcceptNewData_i,
  output logic [7:0]             rdData_o,
  output logic                   rdDataValid_o,
  output logic                   rdIsLastByte_o,
  output logic [$clog2(DEPTH):0] pktCount_o,
  output logic                   overflow_o
`ifdef USB_SIE_PKT_LEN_EN
  ,
  output logic [$clog2(DEPTH):0] rdPktLen_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0] DEPTH_PTR = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DROP} wrState_t;

  wrState_t    state, stateNext;
  logic [8:0]  mem [DEPTH];
  logic [AW:0] wrPtr, specPtr, rdPtr;
  logic [AW:0] wrPtrNext, specPtrNext;
  logic        memWe, commit, ovfNext;
  logic        isFull, lenFull;
  logic        doPop, popLast, doLoad;

  assign isFull  = (specPtr - rdPtr) == DEPTH_PTR;
  assign doPop   = rdDataValid_o && rdAcceptNewData_i;
  assign popLast = doPop && rdIsLastByte_o;
  assign doLoad  = !rdDataValid_o && (rdPtr != wrPtr);

  always_ff @(posedge clk12_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    wrPtrNext   = wrPtr;
    specPtrNext = specPtr;
    memWe       = 1'b0;
    commit      = 1'b0;
    ovfNext     = 1'b0;
    if (wrDataValid_i) begin
      unique case (state)
        DROP: begin
          if (wrIsLastByte_i) begin
            ovfNext   = 1'b1;
            stateNext = IDLE;
          end
        end
        default: begin
          if (isFull) begin
            specPtrNext = wrPtr;
            if (wrIsLastByte_i) begin
              ovfNext   = 1'b1;
              stateNext = IDLE;
            end else begin
              stateNext = DROP;
            end
          end else begin
            memWe       = 1'b1;
            specPtrNext = specPtr + 1'b1;
            if (!wrIsLastByte_i) begin
              stateNext = RECV;
            end else begin
              stateNext = IDLE;
              if (wrKeepPacket_i && !lenFull) begin
                wrPtrNext = specPtr + 1'b1;
                commit    = 1'b1;
              end else begin
                // Rewind; a kept packet refused for lack of a length slot counts as overflow.
                specPtrNext = wrPtr;
                ovfNext     = wrKeepPacket_i;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      wrPtr      <= '0;
      specPtr    <= '0;
      overflow_o <= 1'b0;
    end else begin
      wrPtr      <= wrPtrNext;
      specPtr    <= specPtrNext;
      overflow_o <= ovfNext;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (memWe && !rst_i) mem[specPtr[AW-1:0]] <= {wrIsLastByte_i, wrData_i};
  end

  // Output register refills only while empty, so a pop and a load never share an edge.
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      rdPtr          <= '0;
      rdData_o       <= '0;
      rdDataValid_o  <= 1'b0;
      rdIsLastByte_o <= 1'b0;
    end else if (doPop) begin
      rdDataValid_o  <= 1'b0;
    end else if (doLoad) begin
      {rdIsLastByte_o, rdData_o} <= mem[rdPtr[AW-1:0]];
      rdDataValid_o  <= 1'b1;
      rdPtr          <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i)                    pktCount_o <= '0;
    else if (commit && !popLast)  pktCount_o <= pktCount_o + 1'b1;
    else if (!commit && popLast)  pktCount_o <= pktCount_o - 1'b1;
  end

`ifdef USB_SIE_PKT_LEN_EN
  localparam int LW  = $clog2(MAX_PKTS);
  localparam int LPW = LW + 1;
  localparam logic [LW:0] MAX_PKTS_PTR = LPW'(MAX_PKTS);

  logic [AW:0] lenMem [MAX_PKTS];
  logic [LW:0] lenWr, lenRd;

  assign lenFull    = (lenWr - lenRd) == MAX_PKTS_PTR;
  assign rdPktLen_o = rdDataValid_o ? lenMem[lenRd[LW-1:0]] : '0;

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      lenWr <= '0;
      lenRd <= '0;
    end else begin
      if (commit) begin
        lenMem[lenWr[LW-1:0]] <= specPtr + 1'b1 - wrPtr;
        lenWr <= lenWr + 1'b1;
      end
      if (popLast) lenRd <= lenRd + 1'b1;
    end
  end
`else
  // Without a length FIFO only buffer space limits how many packets queue up.
  assign lenFull = (MAX_PKTS < 1);
`endif

endmodule

// File: doc/usb_sie_pkt_buffer.md
# usb_sie_pkt_buffer

Receive-side packet buffer between the SIE receive datapath and the protocol engine, all in the `clk12_i` domain. It stores each incoming packet speculatively and commits it only if `wrKeepPacket_i` is high on its last byte; otherwise it rewinds the packet. Only whole, committed packets are presented on the read port, so the protocol engine never sees a partial or corrupted packet. Depth is parametrised, multiple packets may be queued, and overflow drops the offending packet rather than stalling the wire.

## Interface
- `DEPTH`, 64: data storage in bytes; power of two, ≥ 4.
- `MAX_PKTS`, 8: queued-packet limit (length FIFO depth); power of two; used only with `USB_SIE_PKT_LEN_EN`.
- `clk12_i`  in  1  sole clock, all logic on posedge.
- `rst_i`  in  1  synchronous, active-high reset.
- `wrDataValid_i`  in  1  `wrData_i` is a new byte; always accepted, with no backpressure.
- `wrData_i`  in  8  received byte.
- `wrIsLastByte_i`  in  1  marks the current byte as the packet's last.
- `wrKeepPacket_i`  in  1  sampled only with last byte; 1 = commit, 0 = discard.
- `rdAcceptNewData_i`  in  1  consumer takes `rdData_o` when `rdDataValid_o` is also high.
- `rdData_o`  out  8  head byte.
- `rdDataValid_o`  out  1  `rdData_o` is valid.
- `rdIsLastByte_o`  out  1  head byte is the last byte of its packet.
- `pktCount_o`  out  $clog2(DEPTH)+1  number of committed packets not yet fully read.
- `overflow_o`  out  1  one-cycle pulse when a packet is dropped for lack of space.
- `rdPktLen_o`  out  $clog2(DEPTH)+1  length of head packet (only with `USB_SIE_PKT_LEN_EN`).

## Operation
- Storage: `DEPTH` × 9 bits (data plus last flag).
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH:
  - `wrPtr` is the committed write pointer.
  - `specPtr` is the speculative write pointer.
  - `rdPtr` is the read pointer.
- Buffer state:
  - Full when `specPtr - rdPtr == DEPTH`.
  - Committed data is present when `rdPtr != wrPtr`.
- Write FSM states are `IDLE`, `RECV` and `DROP`.
  - `IDLE`/`RECV`, a valid byte arrives and the buffer is not full: write it at `specPtr` and increment `specPtr`. Then:
    - If not last: go to `RECV`.
    - If last with keep=1: set `wrPtr` to `specPtr+1`, increment `pktCount_o`, go to `IDLE`.
    - If last with keep=0: set `specPtr` to `wrPtr`, go to `IDLE`.
  - Any valid byte arrives while the buffer is full: do not write it; set `specPtr` to `wrPtr`.
    - If not last: go to `DROP`.
    - If last: pulse `overflow_o`, go to `IDLE`.
  - `DROP`: ignore bytes until a last byte arrives, then pulse `overflow_o` and go to `IDLE`. `wrKeepPacket_i` is ignored in this state.
- Read side uses an output register.
  - It loads `mem[rdPtr]` when empty and `rdPtr != wrPtr`, then increments `rdPtr`.
  - It empties on the handshake `rdDataValid_o && rdAcceptNewData_i`.
  - Popping a byte with the last flag set decrements `pktCount_o`.
- A packet is at minimum one byte (the last byte itself).

## Timing
- Reset values:
  - `rdData_o`=0, `rdDataValid_o`=0, `rdIsLastByte_o`=0, `pktCount_o`=0, `overflow_o`=0, `rdPktLen_o`=0.
  - All pointers are 0 and the FSM is in `IDLE`.
- Reset mid-packet discards the partial packet and all queued packets.
- Latency: the commit edge (last byte, keep=1) is edge N. Then `wrPtr` is visible after N, and `rdDataValid_o` rises after edge N+1, so it is high in cycle N+2.
- Read throughput is one byte per 2 cycles. After a pop at edge M, `rdDataValid_o` is low in cycle M+1 and high again after edge M+1 if data remains.
- Commit and a last-byte pop on the same edge leave `pktCount_o` unchanged.
- A write and a read on the same edge with the buffer full: the full test uses `rdPtr` before the edge, so the byte is dropped.
- `overflow_o` is high for exactly one cycle, in the cycle after the last-byte edge.
- Space freed by reads mid-packet becomes available immediately.

## Configuration
- `USB_SIE_PKT_LEN_EN` defined:
  - Adds a `MAX_PKTS`-deep length FIFO, written on commit with `specPtr+1 - wrPtr`.
  - `rdPktLen_o` shows the head length whenever `rdDataValid_o` is high; the entry is popped with the last byte.
  - A commit with the length FIFO full is treated as overflow: rewind and pulse `overflow_o`.
- Not defined: no length FIFO and no `rdPktLen_o` port. The packet-count limit is DEPTH only.

## Test plan
- Write 3 bytes 0xC3,0x01,0x02 with keep=1 on the last → read 0xC3,0x01,0x02, last flag on 0x02 only; `pktCount_o` goes 0→1→0; `rdDataValid_o` first high 2 cycles after commit.
- Write 5 bytes with keep=0, then 2 bytes 0xAA,0xBB with keep=1 → only 0xAA,0xBB are read; the buffer is empty afterwards.
- DEPTH=64, no reads, write a 70-byte packet → `overflow_o` single pulse after byte 70, nothing readable. A following 4-byte packet is read intact.
- Queue 3 one-byte packets, stall reads, then drain them → `pktCount_o` goes 3,2,1,0. With `USB_SIE_PKT_LEN_EN`, `rdPktLen_o`=1 for each.
- Assert `rst_i` after 10 bytes of a packet with 1 packet queued → next cycle all outputs are at reset values. A new 2-byte packet passes.
- Pointer wrap: stream 200 packets of 7 bytes each through DEPTH=64 with continuous reads → data matches in order, zero overflow pulses.
